game_time_counter: RTL and testbench

//   Elapsed-time counter for the puzzle game. Consumes the one-cycle 1 s pulses

---
 rtl/game_time_counter.sv | 128 ++++++++++++
 tb/tb_game_time_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_time_counter.sv
// Elapsed play-time counter for the puzzle game: MM:SS in BCD, driven by 1 s pulses,
// with start / pause-resume / clear control and an optional time limit.
module game_time_counter #(
    parameter int LIMIT_MIN = 10,
    parameter int LIMIT_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       sec_pulse,
    output logic       timer_en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       time_up
);

    // state    | meaning
    // S_IDLE   | cleared, waiting for start
    // S_RUN    | counting seconds, one_sTimer enabled
    // S_PAUSED | holding time, waiting for start or pause to resume
    // S_DONE   | time limit reached, held until clear or reset
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    localparam logic [3:0] LIM_MT = 4'(LIMIT_MIN / 10);
    localparam logic [3:0] LIM_MO = 4'(LIMIT_MIN % 10);
    localparam logic [3:0] LIM_ST = 4'(LIMIT_SEC / 10);
    localparam logic [3:0] LIM_SO = 4'(LIMIT_SEC % 10);
    localparam logic       LIM_EN = (LIMIT_MIN != 0) || (LIMIT_SEC != 0);

    state_t     r_state;
    logic [3:0] r_so, r_st, r_mo, r_mt;
    logic       r_tick, r_timer_en, r_time_up;

    state_t     w_state_n;
    logic [3:0] w_so_n, w_st_n, w_mo_n, w_mt_n;
    logic       w_count, w_hit;

    assign w_count = (r_state == S_RUN) && sec_pulse;

    // Incremented time with the full carry chain; 99:59 wraps to 00:00.
    always_comb begin
        w_so_n = r_so;
        w_st_n = r_st;
        w_mo_n = r_mo;
        w_mt_n = r_mt;
        if (r_so == 4'd9) begin
            w_so_n = 4'd0;
            if (r_st == 4'd5) begin
                w_st_n = 4'd0;
                if (r_mo == 4'd9) begin
                    w_mo_n = 4'd0;
                    w_mt_n = (r_mt == 4'd9) ? 4'd0 : r_mt + 4'd1;
                end else begin
                    w_mo_n = r_mo + 4'd1;
                end
            end else begin
                w_st_n = r_st + 4'd1;
            end
        end else begin
            w_so_n = r_so + 4'd1;
        end
        w_hit = LIM_EN && ({w_mt_n, w_mo_n, w_st_n, w_so_n} == {LIM_MT, LIM_MO, LIM_ST, LIM_SO});
    end

    always_comb begin
        w_state_n = r_state;
        if (clear) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_state_n = S_RUN;
                S_RUN: begin
                    if (w_count && w_hit) w_state_n = S_DONE;
                    else if (pause)       w_state_n = S_PAUSED;
                end
                S_PAUSED: if (start || pause) w_state_n = S_RUN;
                S_DONE:   w_state_n = S_DONE;
                default:  w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_so       <= 4'd0;
            r_st       <= 4'd0;
            r_mo       <= 4'd0;
            r_mt       <= 4'd0;
            r_tick     <= 1'b0;
            r_timer_en <= 1'b0;
            r_time_up  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_timer_en <= (w_state_n == S_RUN);
            r_time_up  <= (w_state_n == S_DONE);
            if (clear) begin
                r_so   <= 4'd0;
                r_st   <= 4'd0;
                r_mo   <= 4'd0;
                r_mt   <= 4'd0;
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_count;
                if (w_count) begin
                    r_so <= w_so_n;
                    r_st <= w_st_n;
                    r_mo <= w_mo_n;
                    r_mt <= w_mt_n;
                end
            end
        end
    end

    assign timer_en = r_timer_en;
    assign time_up  = r_time_up;
    assign tick     = r_tick;
    assign sec_ones = r_so;
    assign sec_tens = r_st;
    assign min_ones = r_mo;
    assign min_tens = r_mt;

endmodule

// File: tb/tb_game_time_counter.sv
// Bench for game_time_counter: three instances (limit 10:00, limit 00:05, no limit)
// on shared stimulus, checked against an integer-seconds reference model.
module tb_game_time_counter;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0, sec_pulse = 1'b0;

    logic       en [3];
    logic       up [3];
    logic       tk [3];
    logic [3:0] so [3];
    logic [3:0] st [3];
    logic [3:0] mo [3];
    logic [3:0] mt [3];
    logic [18:0] obs [3];

    int checks = 0;
    int errors = 0;

    int lim [3] = '{600, 5, 0};
    int ms  [3];
    int mst [3];
    int mtk [3];

    always #5 clk = ~clk;

    game_time_counter #(.LIMIT_MIN(10), .LIMIT_SEC(0)) u_d0 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .sec_pulse(sec_pulse),
        .timer_en(en[0]), .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
        .tick(tk[0]), .time_up(up[0]));
    game_time_counter #(.LIMIT_MIN(0), .LIMIT_SEC(5)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .sec_pulse(sec_pulse),
        .timer_en(en[1]), .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
        .tick(tk[1]), .time_up(up[1]));
    game_time_counter #(.LIMIT_MIN(0), .LIMIT_SEC(0)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .sec_pulse(sec_pulse),
        .timer_en(en[2]), .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]), .min_tens(mt[2]),
        .tick(tk[2]), .time_up(up[2]));

    always_comb begin
        for (int k = 0; k < 3; k++)
            obs[k] = {mt[k], mo[k], st[k], so[k], en[k], up[k], tk[k]};
    end

    // Reference: elapsed time as plain seconds, game phase as a small integer.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int prev;
            if (!rst) begin
                ms[k] = 0; mst[k] = M_IDLE; mtk[k] = 0;
            end else if (clear) begin
                ms[k] = 0; mst[k] = M_IDLE; mtk[k] = 0;
            end else begin
                prev = mst[k];
                mtk[k] = 0;
                if (prev == M_RUN && sec_pulse) begin
                    ms[k] = (ms[k] + 1) % 6000;
                    mtk[k] = 1;
                end
                if (mtk[k] == 1 && lim[k] != 0 && ms[k] == lim[k]) mst[k] = M_DONE;
                else if (prev == M_IDLE && start)              mst[k] = M_RUN;
                else if (prev == M_RUN && pause)               mst[k] = M_PAUSED;
                else if (prev == M_PAUSED && (start || pause)) mst[k] = M_RUN;
            end
        end
    end

    function automatic logic [18:0] model_vec(input int k);
        int s;
        s = ms[k];
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10),
                mst[k] == M_RUN, mst[k] == M_DONE, mtk[k] == 1};
    endfunction

    function automatic logic [18:0] vec(input int m1, m0, s1, s0, e, u, t);
        return {4'(m1), 4'(m0), 4'(s1), 4'(s0), e[0], u[0], t[0]};
    endfunction

    task automatic step(input logic s, p, c, sp);
        start = s; pause = p; clear = c; sec_pulse = sp;
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; clear = 1'b0; sec_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== vec(0, 0, 0, 0, 0, 0, 0)) begin
                $display("FAIL reset dut%0d got=%h want=%h", k, obs[k], vec(0, 0, 0, 0, 0, 0, 0));
                errors++;
            end
        end
    endtask

    task automatic test_count75();
        int ticks = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 75; i++) begin
            step(0, 0, 0, 1);
            if (tk[0] === 1'b1) ticks++;
            checks++;
            if (obs[0] !== model_vec(0) || en[0] !== 1'b1) begin
                $display("FAIL count75 pulse%0d got=%h want=%h", i, obs[0], model_vec(0));
                errors++;
            end
            step(0, 0, 0, 0);
        end
        checks++;
        if (ticks != 75 || obs[0] !== vec(0, 1, 1, 5, 1, 0, 0)) begin
            $display("FAIL count75_final ticks=%0d got=%h want ticks=75 %h", ticks, obs[0], vec(0, 1, 1, 5, 1, 0, 0));
            errors++;
        end
    endtask

    task automatic test_pause_same_cycle();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (obs[0] !== vec(0, 0, 1, 0, 0, 0, 1)) begin
            $display("FAIL pause_pulse got=%h want=%h", obs[0], vec(0, 0, 1, 0, 0, 0, 1));
            errors++;
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        checks++;
        if (obs[0] !== vec(0, 0, 1, 0, 0, 0, 0)) begin
            $display("FAIL paused_hold got=%h want=%h", obs[0], vec(0, 0, 1, 0, 0, 0, 0));
            errors++;
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        checks++;
        if (obs[0] !== vec(0, 0, 1, 1, 1, 0, 1)) begin
            $display("FAIL resume got=%h want=%h", obs[0], vec(0, 0, 1, 1, 1, 0, 1));
            errors++;
        end
    endtask

    task automatic test_limit();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        checks++;
        if (obs[1] !== vec(0, 0, 0, 4, 1, 0, 1)) begin
            $display("FAIL limit_pre got=%h want=%h", obs[1], vec(0, 0, 0, 4, 1, 0, 1));
            errors++;
        end
        step(0, 0, 0, 1);
        checks++;
        if (obs[1] !== vec(0, 0, 0, 5, 0, 1, 1)) begin
            $display("FAIL limit_hit got=%h want=%h", obs[1], vec(0, 0, 0, 5, 0, 1, 1));
            errors++;
        end
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (obs[1] !== vec(0, 0, 0, 5, 0, 1, 0)) begin
            $display("FAIL limit_hold got=%h want=%h", obs[1], vec(0, 0, 0, 5, 0, 1, 0));
            errors++;
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs[1] !== vec(0, 0, 0, 0, 0, 0, 0)) begin
            $display("FAIL limit_clear got=%h want=%h", obs[1], vec(0, 0, 0, 0, 0, 0, 0));
            errors++;
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5999; i++) step(0, 0, 0, 1);
        checks++;
        if (obs[2] !== vec(9, 9, 5, 9, 1, 0, 1)) begin
            $display("FAIL wrap_pre got=%h want=%h", obs[2], vec(9, 9, 5, 9, 1, 0, 1));
            errors++;
        end
        checks++;
        if (obs[0] !== vec(1, 0, 0, 0, 0, 1, 0)) begin
            $display("FAIL limit_10min got=%h want=%h", obs[0], vec(1, 0, 0, 0, 0, 1, 0));
            errors++;
        end
        step(0, 0, 0, 1);
        checks++;
        if (obs[2] !== vec(0, 0, 0, 0, 1, 0, 1)) begin
            $display("FAIL wrap got=%h want=%h", obs[2], vec(0, 0, 0, 0, 1, 0, 1));
            errors++;
        end
    endtask

    task automatic test_clear_start();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
        checks++;
        if (obs[0] !== vec(0, 0, 3, 0, 1, 0, 1)) begin
            $display("FAIL clr_pre got=%h want=%h", obs[0], vec(0, 0, 3, 0, 1, 0, 1));
            errors++;
        end
        step(1, 0, 1, 1);
        checks++;
        if (obs[0] !== vec(0, 0, 0, 0, 0, 0, 0)) begin
            $display("FAIL clear_start got=%h want=%h", obs[0], vec(0, 0, 0, 0, 0, 0, 0));
            errors++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
            rst = 1'b1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    $display("FAIL random dut%0d cyc%0d got=%h want=%h", k, i, obs[k], model_vec(k));
                    errors++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count75();
        test_pause_same_cycle();
        test_limit();
        test_wrap();
        test_clear_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
